// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the countdown timer slice.
// Build option: COUNTDOWN_AUTORELOAD_EN (see countdown_timer.sv).
package countdown_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/down_counter_core.sv
// N-bit down counter register with clear, load and decrement-enable.
// Priority is clear over load over decrement; it saturates at zero.
module down_counter_core
  import countdown_pkg::*;
#(
  parameter int N = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic         dec,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - N'(1);
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Three-state countdown timer (IDLE/RUN/DONE) with registered count/busy/done.
// Build option: COUNTDOWN_AUTORELOAD_EN reloads the start value at terminal count.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int N = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] load_val,
  input  logic         en,
  input  logic         abort,
  output logic [N-1:0] count,
  output logic         busy,
  output logic         done
);

  state_t       state, state_n;
  logic         busy_n, done_n;
  logic         cnt_clear, cnt_load, cnt_dec;
  logic [N-1:0] cnt_data;
  logic         last_tick;

  assign last_tick = (count <= N'(1));

`ifdef COUNTDOWN_AUTORELOAD_EN
  // Start value remembered for reloading at each terminal count.
  logic [N-1:0] reload_val;

  always_ff @(posedge clk) begin
    if (reset) begin
      reload_val <= '0;
    end else if ((state != RUN) && start && (load_val != '0)) begin
      reload_val <= load_val;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    done_n    = 1'b0;
    cnt_clear = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_data  = load_val;
    case (state)
      RUN: begin
        if (abort) begin
          state_n   = IDLE;
          cnt_clear = 1'b1;
        end else if (en) begin
          if (last_tick) begin
`ifdef COUNTDOWN_AUTORELOAD_EN
            cnt_load = 1'b1;
            cnt_data = reload_val;
            done_n   = 1'b1;
`else
            state_n   = DONE;
            cnt_clear = 1'b1;
            done_n    = 1'b1;
`endif
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      default: begin
        // IDLE and DONE share start handling; DONE otherwise falls back to IDLE.
        cnt_clear = 1'b1;
        state_n   = IDLE;
        if (start) begin
          if (load_val != '0) begin
            state_n   = RUN;
            cnt_clear = 1'b0;
            cnt_load  = 1'b1;
          end else begin
            state_n = DONE;
            done_n  = 1'b1;
          end
        end
      end
    endcase
    busy_n = (state_n == RUN);
  end

  down_counter_core #(.N(N)) u_core (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clear),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_data),
    .count    (count)
  );

endmodule
